bank_write_scheduler: RTL

BANK_WRITE_SCHEDULER -- requirements
Module: Bank_Write_Scheduler

---
 rtl/bank_write_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/bank_write_scheduler.sv
// ---------------------------------------------------------------------------
// bank_write_scheduler
//
// Distributes an incoming pixel stream across BANK_COUNT parallel line-buffer
// banks, each holding BLOCK_DEPTH words per buffer half. Pixels fill the banks
// round-robin (bank 0, 1, .. BANK_COUNT-1, then the word address advances).
// When the last word of the last bank is written, the half is complete: a
// one-cycle O_block_ready pulse is issued and the write side moves on to the
// other half. At most two halves can be full at once; a third completion is
// impossible, so with both halves full the block stalls and drops pixels
// until the reader releases a half.
//
// Ports
//   I_clk          single clock, rising edge
//   I_rst_n        asynchronous active-low reset
//   I_enable       level; low holds the block in IDLE
//   I_frame_start  pulse; restart filling of the current half at bank 0, addr 0
//   I_pixel_valid  qualifies I_pixel_data
//   I_pixel_data   incoming pixel
//   I_release      pulse; reader has consumed the oldest full half
//   O_bank_we      one-hot-or-zero bank write enable (registered)
//   O_bank_addr    word address shared by all banks (registered)
//   O_bank_half    buffer half being written (registered)
//   O_bank_data    write data shared by all banks (registered)
//   O_block_ready  one-cycle pulse, coincident with the write completing a half
//   O_ready_half   index of the completed half, valid with O_block_ready
//   O_overflow     sticky; a pixel was dropped while stalled
// ---------------------------------------------------------------------------
module bank_write_scheduler #(
    parameter int BANK_COUNT  = 3,
    parameter int BLOCK_DEPTH = 480,
    parameter int DATA_WIDTH  = 24
) (
    input  logic                           I_clk,
    input  logic                           I_rst_n,
    input  logic                           I_enable,
    input  logic                           I_frame_start,
    input  logic                           I_pixel_valid,
    input  logic [DATA_WIDTH-1:0]          I_pixel_data,
    input  logic                           I_release,
    output logic [BANK_COUNT-1:0]          O_bank_we,
    output logic [$clog2(BLOCK_DEPTH)-1:0] O_bank_addr,
    output logic                           O_bank_half,
    output logic [DATA_WIDTH-1:0]          O_bank_data,
    output logic                           O_block_ready,
    output logic                           O_ready_half,
    output logic                           O_overflow
);

    localparam int AW = $clog2(BLOCK_DEPTH);
    localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;

    localparam logic [BW-1:0] BANK_LAST = BW'(BANK_COUNT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(BLOCK_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [BW-1:0] bank_q, bank_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          half_q, half_nxt;
    logic [1:0]    full_q, full_nxt;

    logic [BANK_COUNT-1:0] we_nxt;
    logic [AW-1:0]         addr_o_nxt;
    logic                  half_o_nxt;
    logic [DATA_WIDTH-1:0] data_o_nxt;
    logic                  rdy_nxt;
    logic                  rdy_half_nxt;
    logic                  ovf_nxt;

    // Write position after a coincident frame start has been applied.
    logic [BW-1:0] bank_eff;
    logic [AW-1:0] addr_eff;
    logic          rel_ok;
    logic          done;

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= IDLE;
            bank_q        <= '0;
            addr_q        <= '0;
            half_q        <= 1'b0;
            full_q        <= 2'd0;
            O_bank_we     <= '0;
            O_bank_addr   <= '0;
            O_bank_half   <= 1'b0;
            O_bank_data   <= '0;
            O_block_ready <= 1'b0;
            O_ready_half  <= 1'b0;
            O_overflow    <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            bank_q        <= bank_nxt;
            addr_q        <= addr_nxt;
            half_q        <= half_nxt;
            full_q        <= full_nxt;
            O_bank_we     <= we_nxt;
            O_bank_addr   <= addr_o_nxt;
            O_bank_half   <= half_o_nxt;
            O_bank_data   <= data_o_nxt;
            O_block_ready <= rdy_nxt;
            O_ready_half  <= rdy_half_nxt;
            O_overflow    <= ovf_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state, counters and write outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt    = state_q;
        bank_nxt     = bank_q;
        addr_nxt     = addr_q;
        half_nxt     = half_q;
        full_nxt     = full_q;
        we_nxt       = '0;
        addr_o_nxt   = O_bank_addr;
        half_o_nxt   = O_bank_half;
        data_o_nxt   = O_bank_data;
        rdy_nxt      = 1'b0;
        rdy_half_nxt = O_ready_half;
        ovf_nxt      = O_overflow;
        done         = 1'b0;

        bank_eff = I_frame_start ? '0 : bank_q;
        addr_eff = I_frame_start ? '0 : addr_q;
        // A release with nothing full has nothing to free.
        rel_ok   = I_release && (full_q != 2'd0);

        case (state_q)
            IDLE: begin
                bank_nxt = '0;
                addr_nxt = '0;
                if (rel_ok) begin
                    full_nxt = full_q - 2'd1;
                end
                // Re-enabling with both halves still full must not overwrite them.
                if (I_enable) begin
                    state_nxt = (full_nxt == 2'd2) ? STALL : FILL;
                end
            end

            FILL: begin
                if (!I_enable) begin
                    state_nxt = IDLE;
                    bank_nxt  = '0;
                    addr_nxt  = '0;
                    if (rel_ok) begin
                        full_nxt = full_q - 2'd1;
                    end
                end else begin
                    bank_nxt = bank_eff;
                    addr_nxt = addr_eff;
                    if (I_pixel_valid) begin
                        we_nxt     = BANK_COUNT'(1) << bank_eff;
                        addr_o_nxt = addr_eff;
                        half_o_nxt = half_q;
                        data_o_nxt = I_pixel_data;
                        if (bank_eff == BANK_LAST) begin
                            bank_nxt = '0;
                            if (addr_eff == ADDR_LAST) begin
                                addr_nxt = '0;
                                done     = 1'b1;
                            end else begin
                                addr_nxt = addr_eff + AW'(1);
                            end
                        end else begin
                            bank_nxt = bank_eff + BW'(1);
                        end
                    end

                    if (done) begin
                        rdy_nxt      = 1'b1;
                        rdy_half_nxt = half_q;
                        half_nxt     = ~half_q;
                    end

                    // Completion and release together cancel out.
                    if (done && !rel_ok) begin
                        full_nxt = full_q + 2'd1;
                    end else if (!done && rel_ok) begin
                        full_nxt = full_q - 2'd1;
                    end

                    if (full_nxt == 2'd2) begin
                        state_nxt = STALL;
                    end
                end
            end

            STALL: begin
                if (!I_enable) begin
                    state_nxt = IDLE;
                    bank_nxt  = '0;
                    addr_nxt  = '0;
                    if (rel_ok) begin
                        full_nxt = full_q - 2'd1;
                    end
                end else begin
                    if (I_frame_start) begin
                        bank_nxt = '0;
                        addr_nxt = '0;
                    end
                    // Pixels arriving while both halves are full are lost.
                    if (I_pixel_valid) begin
                        ovf_nxt = 1'b1;
                    end
                    if (rel_ok) begin
                        full_nxt  = full_q - 2'd1;
                        state_nxt = FILL;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                bank_nxt  = '0;
                addr_nxt  = '0;
            end
        endcase
    end

endmodule
